// File: rtl/stack_reverse_ctrl.sv
// rtl/stack_reverse_ctrl.sv - push/pop initiator that reverses a digit frame through an external stack
// Fills the stack from the input stream, then pops one digit per three cycles onto the output stream.
module stack_reverse_ctrl #(
  parameter int DW    = 4,
  parameter int DEPTH = 32,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          stk_rst,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  input  logic          stk_empty,
  output logic          err_ovf,
  output logic          err_sync
);

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    POP   = 3'd1,
    CAPT  = 3'd2,
    SEND  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          frame_ovf;
  logic          accept;

  always_comb begin
    in_ready = 1'b0;
    if (state == FILL)
      in_ready = (count < DEPTH_C);
    else if (state == FLUSH)
      in_ready = 1'b1;
  end

  assign accept   = in_valid & in_ready;
  assign stk_din  = in_data;
  assign stk_rst  = ~rst | (state == FLUSH);
  // Strobes are gated by reset so nothing reaches the stack on the clearing edge.
  assign stk_push = rst & (state == FILL) & accept;
  assign stk_pop  = rst & (state == POP) & (count != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FILL;
      count     <= '0;
      frame_ovf <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      err_ovf   <= 1'b0;
      err_sync  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if ((count == '0) && !stk_empty)
            err_sync <= 1'b1;
          if (accept) begin
            count <= count + CW'(1);
            if (in_last) begin
              state <= POP;
            end else if (count == LAST_C) begin
              // Stack is now full: truncate and let FLUSH swallow the tail.
              err_ovf   <= 1'b1;
              frame_ovf <= 1'b1;
              state     <= POP;
            end
          end
        end
        POP: begin
          if (stk_empty)
            err_sync <= 1'b1;
          if (count != '0)
            count <= count - CW'(1);
          state <= CAPT;
        end
        CAPT: begin
          out_data  <= stk_dout;
          out_last  <= (count == '0);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!out_last) begin
              state <= POP;
            end else if (frame_ovf) begin
              frame_ovf <= 1'b0;
              state     <= FLUSH;
            end else begin
              state <= FILL;
            end
          end
        end
        FLUSH: begin
          if (accept && in_last)
            state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
